eq_gain_scheduler: RTL and testbench
====================================

# eq_gain_scheduler

Double-buffered equaliser gain table and update sequencer for the EQ quantiser stage. Software loads per-channel gains through a 32-bit software register into a shadow bank. Swap requests are deferred to the next spectrum sync, so the datapath never sees a partly updated table. Read-back status goes to a second software register.

## Interface
Parameters:
- `N_CHAN_BITS`, default 10: channel address width (1024 channels).
- `GAIN_W`, default 16: gain word width, unsigned, at most 16.
- `DEFAULT_GAIN`, default 16'h0100: value loaded into both banks after reset.

Ports (clock and reset first):
- `user_clk`, in, 1: single clock for the whole block.
- `user_rst_n`, in, 1: asynchronous, active-low reset.
- `ctrl_word`, in, 32: software register output, already in `user_clk` domain.
  - [31]: write toggle.
  - [30]: swap toggle.
  - [16+N_CHAN_BITS-1:16]: channel address.
  - [GAIN_W-1:0]: gain.
- `sync_in`, in, 1: spectrum-start pulse, one cycle.
- `rd_chan`, in, N_CHAN_BITS: datapath channel index for each cycle.
- `gain_out`, out, GAIN_W: gain for `rd_chan`.
- `sync_out`, out, 1: `sync_in` aligned to `gain_out`.
- `status_word`, out, 32: to the read-back register.
  - [31:16]: write count.
  - [2]: init_busy.
  - [1]: swap_pending.
  - [0]: active_bank.

## Operation
The FSM has three states: INIT, IDLE, PEND.

- **Reset** (any time, including mid-write or mid-INIT):
  - State goes to INIT and the INIT counter to 0.
  - active_bank=0, swap_pending=0, write count=0.
  - Previous toggle samples = 0.
  - `gain_out`=0, `sync_out`=0, status init_busy=1.
- **INIT:**
  - One address per cycle; DEFAULT_GAIN is written to both banks at that address.
  - Lasts 2^N_CHAN_BITS cycles, then goes to IDLE.
  - Toggle edges during INIT are dropped, but the previous samples still track `ctrl_word`.
  - `gain_out` is forced to DEFAULT_GAIN (after the normal latency).
  - `sync_in` is still forwarded.
- **Write:**
  - A write toggle edge is `ctrl_word[31]` differing from its previous-cycle sample.
  - Effect: write gain to address in bank ~active_bank; write count +1, wrapping at 16 bits.
  - Allowed in both IDLE and PEND.
- **Swap request:**
  - A swap toggle edge is `ctrl_word[30]` differing from its previous sample.
  - In IDLE: go to PEND and set swap_pending=1.
  - In PEND: ignored (requests do not queue).
- **PEND:**
  - On `sync_in`=1: active_bank flips, swap_pending clears, state returns to IDLE.
  - The flip is visible to the read issued in the same cycle as `sync_in`: read bank select = active_bank XOR (PEND & `sync_in`).
- **Write and swap-flip in the same cycle:** the write targets the pre-flip shadow bank, which becomes active. The datapath first sees that write on the following cycle.
- **After a swap:** the new shadow holds the stale table. There is no auto-copy; software rewrites every channel it needs.

## Timing
- Read latency is 2 cycles: `rd_chan` is registered, the RAM read is registered, and `gain_out` is valid on cycle N+2. `sync_out` = `sync_in` delayed by 2 cycles.
- Write: 1 cycle after the toggle edge is sampled. The new value is readable from the shadow bank with no extra hazard; the datapath never reads the shadow.
- Throughput: one write per cycle, limited only by the toggle rate; software is far slower.
- `status_word` is registered and updates 1 cycle after the event.
- INIT takes exactly 2^N_CHAN_BITS cycles. init_busy falls on the cycle the state enters IDLE.

## Structure
- Package `eq_gain_pkg`:
  - State enum {INIT, IDLE, PEND}.
  - `ctrl_word` field bit positions.
  - Status bit positions.
- Sub-module `eq_gain_ram`:
  - Two banks of 2^N_CHAN_BITS × GAIN_W, simple dual-port (one write port, one registered read port).
  - The bank is the address MSB.
  - During INIT, the write enable covers both banks.

## Test plan
- **Reset, then INIT:**
  - init_busy=1 for 1024 cycles; any `rd_chan` returns 16'h0100.
  - Write toggles during INIT leave the write count at 0.
- **Shadow write:**
  - Stimulus: `ctrl_word`=32'h8005_1234 (write toggle flipped, address 5).
  - Reading channel 5 still returns 16'h0100 and the write count becomes 1.
  - After a swap toggle plus a `sync_in`, `rd_chan`=5 gives 16'h1234 two cycles later.
- **Swap deferral:**
  - Stimulus: swap toggle, then no sync for 100 cycles.
  - swap_pending=1 and active_bank=0 throughout; on `sync_in`, active_bank=1 and the read in the sync cycle uses bank 1.
- **Duplicate swap request:**
  - Stimulus: two swap toggles before a sync.
  - Exactly one flip occurs.
- **Write and flip in the same cycle:**
  - Stimulus: address 7, gain 16'hABCD.
  - The value appears in the new active bank; the read in the flip cycle returns the old contents of that bank, and the next read returns 16'hABCD.
- **Reset mid-PEND:**
  - Stimulus: assert `user_rst_n` low with swap_pending=1.
  - swap_pending=0, active_bank=0, INIT restarts.

Source files
------------

// File: rtl/eq_gain_pkg.sv
// Shared constants for the EQ gain scheduler: FSM encodings,
// control-word field positions and status-word bit positions.
package eq_gain_pkg;

  // Sequencer states
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // ctrl_word field positions
  localparam int CW_WR_TOG   = 31;
  localparam int CW_SWAP_TOG = 30;
  localparam int CW_ADDR_LSB = 16;

  // status_word field positions
  localparam int SB_WR_CNT_LSB  = 16;
  localparam int SB_INIT_BUSY   = 2;
  localparam int SB_SWAP_PEND   = 1;
  localparam int SB_ACTIVE_BANK = 0;

endpackage

// File: rtl/eq_gain_ram.sv
// Two-bank gain table. Each bank is a simple dual-port RAM with one write
// port and a registered read port; the bank select acts as the address MSB.
// we_both lets the initialiser fill the same address in both banks at once.
module eq_gain_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              we_both,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic rd_bank_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [2**ADDR_W];
      logic [DATA_W-1:0] q;
      logic              bank_we;

      assign bank_we = we & (we_both | (wr_bank == 1'(gi)));

      // Read-first bank: a read and write to the same word on one edge
      // returns the old contents.
      always_ff @(posedge clk) begin
        if (bank_we) begin
          mem[wr_addr] <= wr_data;
        end
        q <= mem[rd_addr];
      end
    end
  endgenerate

  // Bank select follows the read data through the RAM output register
  always_ff @(posedge clk) begin
    rd_bank_q <= rd_bank;
  end

  assign rd_data = rd_bank_q ? g_bank[1].q : g_bank[0].q;

endmodule

// File: rtl/eq_gain_scheduler.sv
// Double-buffered EQ gain table with toggle-driven software writes into the
// shadow bank and bank swaps deferred to the next spectrum sync.
module eq_gain_scheduler
  import eq_gain_pkg::*;
#(
  parameter int          N_CHAN_BITS  = 10,
  parameter int          GAIN_W       = 16,
  parameter logic [15:0] DEFAULT_GAIN = 16'h0100
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic [31:0]            ctrl_word,
  input  logic                   sync_in,
  input  logic [N_CHAN_BITS-1:0] rd_chan,
  output logic [GAIN_W-1:0]      gain_out,
  output logic                   sync_out,
  output logic [31:0]            status_word
);

  logic [1:0]             state_reg, state_next;
  logic [N_CHAN_BITS-1:0] init_cnt_reg;
  logic                   active_bank_reg;
  logic [15:0]            wr_cnt_reg;
  logic                   prev_wr_tog_reg, prev_sw_tog_reg;

  logic                   wr_en_reg, wr_bank_reg;
  logic [N_CHAN_BITS-1:0] wr_addr_reg;
  logic [GAIN_W-1:0]      wr_data_reg;

  logic [N_CHAN_BITS:0]   rd_addr_reg;
  logic                   vld_d1_reg, vld_d2_reg;
  logic                   init_d1_reg, init_d2_reg;
  logic                   sync_d1_reg, sync_d2_reg;

  logic                   in_init, in_pend, wr_edge, sw_edge, flip, rd_bank_sel;
  logic                   ram_we;
  logic [N_CHAN_BITS-1:0] ram_wr_addr;
  logic [GAIN_W-1:0]      ram_wr_data, ram_rd_data;
  logic                   unused_ctrl_bits;

  assign in_init = (state_reg == ST_INIT);
  assign in_pend = (state_reg == ST_PEND);

  // Toggle edges are ignored while the table is being initialised
  assign wr_edge = (ctrl_word[CW_WR_TOG] != prev_wr_tog_reg) && !in_init;
  assign sw_edge = (ctrl_word[CW_SWAP_TOG] != prev_sw_tog_reg) && !in_init;

  // The swap takes effect for the read issued in the sync cycle itself
  assign flip        = in_pend && sync_in;
  assign rd_bank_sel = active_bank_reg ^ flip;

  // Not every control bit is a field; fold the rest away
  assign unused_ctrl_bits = ^ctrl_word;

  // Next-state logic for the init / idle / pending-swap sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT: if (init_cnt_reg == {N_CHAN_BITS{1'b1}}) state_next = ST_IDLE;
      ST_IDLE: if (sw_edge) state_next = ST_PEND;
      ST_PEND: if (sync_in) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  // Sequencer state, bank pointer, write counter and toggle history
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_reg       <= ST_INIT;
      init_cnt_reg    <= '0;
      active_bank_reg <= 1'b0;
      wr_cnt_reg      <= '0;
      prev_wr_tog_reg <= 1'b0;
      prev_sw_tog_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_wr_tog_reg <= ctrl_word[CW_WR_TOG];
      prev_sw_tog_reg <= ctrl_word[CW_SWAP_TOG];
      if (in_init) begin
        init_cnt_reg <= init_cnt_reg + N_CHAN_BITS'(1);
      end
      if (flip) begin
        active_bank_reg <= ~active_bank_reg;
      end
      if (wr_edge) begin
        wr_cnt_reg <= wr_cnt_reg + 16'd1;
      end
    end
  end

  // Capture a software write aimed at the current (pre-flip) shadow bank.
  // Committing it one cycle later keeps a same-cycle flip read on old data.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_bank_reg <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg   <= wr_edge;
      wr_bank_reg <= ~active_bank_reg;
      wr_addr_reg <= ctrl_word[CW_ADDR_LSB +: N_CHAN_BITS];
      wr_data_reg <= ctrl_word[GAIN_W-1:0];
    end
  end

  // Read address register plus the side-band pipeline that tracks the RAM
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      rd_addr_reg <= '0;
      vld_d1_reg  <= 1'b0;
      vld_d2_reg  <= 1'b0;
      init_d1_reg <= 1'b1;
      init_d2_reg <= 1'b1;
      sync_d1_reg <= 1'b0;
      sync_d2_reg <= 1'b0;
    end else begin
      rd_addr_reg <= {rd_bank_sel, rd_chan};
      vld_d1_reg  <= 1'b1;
      vld_d2_reg  <= vld_d1_reg;
      init_d1_reg <= in_init;
      init_d2_reg <= init_d1_reg;
      sync_d1_reg <= sync_in;
      sync_d2_reg <= sync_d1_reg;
    end
  end

  // Initialiser owns the write port while filling both banks
  assign ram_we      = in_init | wr_en_reg;
  assign ram_wr_addr = in_init ? init_cnt_reg : wr_addr_reg;
  assign ram_wr_data = in_init ? DEFAULT_GAIN[GAIN_W-1:0] : wr_data_reg;

  eq_gain_ram #(
    .ADDR_W (N_CHAN_BITS),
    .DATA_W (GAIN_W)
  ) u_ram (
    .clk     (user_clk),
    .we      (ram_we),
    .we_both (in_init),
    .wr_bank (wr_bank_reg),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_bank (rd_addr_reg[N_CHAN_BITS]),
    .rd_addr (rd_addr_reg[N_CHAN_BITS-1:0]),
    .rd_data (ram_rd_data)
  );

  assign gain_out = !vld_d2_reg ? '0 :
                    init_d2_reg ? DEFAULT_GAIN[GAIN_W-1:0] : ram_rd_data;
  assign sync_out = sync_d2_reg;

  // Status read-back assembled from registered state
  always_comb begin
    status_word                            = '0;
    status_word[SB_WR_CNT_LSB +: 16]       = wr_cnt_reg;
    status_word[SB_INIT_BUSY]              = in_init;
    status_word[SB_SWAP_PEND]              = in_pend;
    status_word[SB_ACTIVE_BANK]            = active_bank_reg;
  end

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: init fill, shadow writes, deferred
// swaps, duplicate requests, write-with-flip and reset while pending.
module tb_eq_gain_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl_word;
  logic        sync_in;
  logic [9:0]  rd_chan;
  logic [15:0] gain_out;
  logic        sync_out;
  logic [31:0] status_word;

  int total = 0;
  int bad   = 0;

  eq_gain_scheduler #(
    .N_CHAN_BITS  (10),
    .GAIN_W       (16),
    .DEFAULT_GAIN (16'h0100)
  ) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .ctrl_word   (ctrl_word),
    .sync_in     (sync_in),
    .rd_chan     (rd_chan),
    .gain_out    (gain_out),
    .sync_out    (sync_out),
    .status_word (status_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a channel and check the value returned two cycles later
  task automatic rd_chk(input string tag, input logic [9:0] ch, input logic [15:0] exp);
    rd_chan = ch;
    tick();
    tick();
    chk(tag, {16'h0, gain_out}, {16'h0, exp});
  endtask

  // Walk through INIT, toggling both control bits twice along the way
  task automatic run_init(input string tag);
    int n;
    n = 0;
    while (status_word[2] && n < 2000) begin
      if (n == 10 || n == 12) ctrl_word[31] = ~ctrl_word[31];
      if (n == 20 || n == 22) ctrl_word[30] = ~ctrl_word[30];
      if (n == 30) rd_chan = 10'd3;
      if (n == 50) chk({tag, "_gain"}, {16'h0, gain_out}, 32'h0000_0100);
      if (n == 100) chk({tag, "_wcnt"}, {16'h0, status_word[31:16]}, 32'h0);
      tick();
      n++;
    end
    chk({tag, "_len"}, n, 32'd1024);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ctrl_word = 32'h0;
    sync_in   = 1'b0;
    rd_chan   = 10'd0;
    tick();
    tick();
    chk("rst_gain",   {16'h0, gain_out}, 32'h0);
    chk("rst_sync",   {31'h0, sync_out}, 32'h0);
    chk("rst_status", status_word, 32'h0000_0004);
    rst_n = 1'b1;

    run_init("init1");
    chk("post_init_status", status_word, 32'h0000_0000);

    // Shadow write to channel 5
    ctrl_word = 32'h8005_1234;
    tick();
    chk("sh_wcnt", status_word, 32'h0001_0000);
    rd_chk("sh_active_old", 10'd5, 16'h0100);

    // Swap request deferred until sync
    ctrl_word = 32'hC005_1234;
    tick();
    chk("sw_pend", status_word, 32'h0001_0002);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("sw_defer", status_word, 32'h0001_0002);
    end
    sync_in = 1'b1;
    rd_chan = 10'd5;
    tick();
    sync_in = 1'b0;
    chk("sw_flip_status", status_word, 32'h0001_0001);
    chk("sw_sync_d1", {31'h0, sync_out}, 32'h0);
    tick();
    chk("sw_sync_d2", {31'h0, sync_out}, 32'h1);
    chk("sw_flip_read", {16'h0, gain_out}, 32'h0000_1234);
    tick();
    chk("sw_sync_d3", {31'h0, sync_out}, 32'h0);

    // Two swap toggles before one sync: exactly one flip
    ctrl_word = 32'h8005_1234;
    tick();
    chk("dup_pend1", status_word, 32'h0001_0003);
    ctrl_word = 32'hC005_1234;
    tick();
    chk("dup_pend2", status_word, 32'h0001_0003);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("dup_flip", status_word, 32'h0001_0000);
    repeat (5) tick();
    chk("dup_once", status_word, 32'h0001_0000);
    rd_chk("dup_read", 10'd5, 16'h0100);

    // Write and flip in the same cycle
    ctrl_word = 32'h8005_1234;
    tick();
    chk("wf_pend", status_word, 32'h0001_0002);
    ctrl_word = 32'h0007_ABCD;
    sync_in   = 1'b1;
    rd_chan   = 10'd7;
    tick();
    sync_in = 1'b0;
    tick();
    chk("wf_old", {16'h0, gain_out}, 32'h0000_0100);
    tick();
    chk("wf_new", {16'h0, gain_out}, 32'h0000_ABCD);
    chk("wf_status", status_word, 32'h0002_0001);
    rd_chk("wf_ch5", 10'd5, 16'h1234);

    // Reset while a swap is pending
    ctrl_word = 32'h4007_ABCD;
    tick();
    chk("rp_pend", status_word, 32'h0002_0003);
    rst_n = 1'b0;
    #2;
    chk("rp_status", status_word, 32'h0000_0004);
    chk("rp_gain", {16'h0, gain_out}, 32'h0);
    tick();
    rst_n = 1'b1;
    run_init("init2");
    chk("rp_post_status", status_word, 32'h0000_0000);
    rd_chk("rp_ch7", 10'd7, 16'h0100);
    rd_chk("rp_ch5", 10'd5, 16'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
